// File: rtl/aes_mix_pkg.sv
// Shared definitions for the streaming MixColumns stage.
//   AES_POLY  : low byte of the AES field polynomial 0x11B, folded in by xtime
//   col_t     : one 32-bit state column, row 0 in [31:24], row 3 in [7:0]
//   xtime     : multiply by 2 in GF(2^8)
//   gf_mul3   : multiply by 3 in GF(2^8)
//   gf_mul9/B/D/E : inverse-transform multipliers, present only when
//                   MIXCOL_INV_EN is defined
package aes_mix_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef logic [31:0] col_t;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

`ifdef MIXCOL_INV_EN
  // 9 = 8+1, B = 8+2+1, D = 8+4+1, E = 8+4+2
  function automatic logic [7:0] gf_mul9(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ x;
  endfunction

  function automatic logic [7:0] gf_mulB(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
  endfunction

  function automatic logic [7:0] gf_mulD(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
  endfunction

  function automatic logic [7:0] gf_mulE(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
  endfunction
`endif

endpackage

// File: rtl/mix_column_comb.sv
// Purely combinational MixColumns of one column.
// Ports:
//   col_in  : input column {a0,a1,a2,a3}, a0 in [31:24]
//   bypass  : pass col_in straight through (final round); wins over inv
//   inv     : select InvMixColumns (port exists only with MIXCOL_INV_EN)
//   col_out : transformed column {b0,b1,b2,b3}
module mix_column_comb
  import aes_mix_pkg::*;
(
  input  logic [31:0] col_in,
  input  logic        bypass,
`ifdef MIXCOL_INV_EN
  input  logic        inv,
`endif
  output logic [31:0] col_out
);

  logic [7:0] a0, a1, a2, a3;
  col_t       fwd_col;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  // Circulant matrix 02 03 01 01, rotated one place right per row.
  assign fwd_col = {xtime(a0)   ^ gf_mul3(a1) ^ a2          ^ a3,
                    a0          ^ xtime(a1)   ^ gf_mul3(a2) ^ a3,
                    a0          ^ a1          ^ xtime(a2)   ^ gf_mul3(a3),
                    gf_mul3(a0) ^ a1          ^ a2          ^ xtime(a3)};

`ifdef MIXCOL_INV_EN
  col_t inv_col;

  // Circulant matrix 0E 0B 0D 09, same rotation as the forward path.
  assign inv_col = {gf_mulE(a0) ^ gf_mulB(a1) ^ gf_mulD(a2) ^ gf_mul9(a3),
                    gf_mul9(a0) ^ gf_mulE(a1) ^ gf_mulB(a2) ^ gf_mulD(a3),
                    gf_mulD(a0) ^ gf_mul9(a1) ^ gf_mulE(a2) ^ gf_mulB(a3),
                    gf_mulB(a0) ^ gf_mulD(a1) ^ gf_mul9(a2) ^ gf_mulE(a3)};

  assign col_out = bypass ? col_in : (inv ? inv_col : fwd_col);
`else
  assign col_out = bypass ? col_in : fwd_col;
`endif

endmodule

// File: rtl/mix_columns_stream.sv
// Streaming MixColumns stage. Collects state bytes column-major, LANES bytes
// per beat, and emits one transformed 32-bit column per output transfer.
// Optional feature: define MIXCOL_INV_EN to add the decrypt port and the
// InvMixColumns path.
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   : input beat handshake
//   in_data[8*LANES-1:0]: lane k carries row (byte_cnt + k), lane 0 = [7:0]
//   bypass              : final-round pass-through, taken from a column's first beat
//   decrypt             : InvMixColumns select, taken from a column's first beat
//   out_valid/out_ready : output column handshake
//   out_col[31:0]       : result column, row 0 in [31:24]
//   out_last            : out_col is column NB-1 of the block
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; the producer holds valid and its payload stable until that edge,
// and the consumer may change ready freely.
module mix_columns_stream
  import aes_mix_pkg::*;
#(
  parameter int LANES = 1,
  parameter int NB    = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic               bypass,
`ifdef MIXCOL_INV_EN
  input  logic               decrypt,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_col,
  output logic               out_last
);

  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
    $error("mix_columns_stream: LANES must be 1, 2 or 4");
  end
  if (NB < 1 || NB > 8) begin : g_bad_nb
    $error("mix_columns_stream: NB must be in 1..8");
  end

  // With LANES=4 the step truncates to 0, so the byte counter stays at 0 and
  // every beat is both the first and the final beat of its column.
  localparam logic [1:0] LANE_STEP     = 2'(LANES);
  localparam logic [1:0] LAST_BYTE_CNT = 2'(4 - LANES);
  localparam logic [2:0] LAST_COL      = 3'(NB - 1);

  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [2:0]  col_cnt_q, col_cnt_d;
  logic [7:0]  row_q [4];
  logic [7:0]  row_d [4];
  logic        bypass_q, bypass_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_col_q, out_col_d;
  logic        out_last_q, out_last_d;
`ifdef MIXCOL_INV_EN
  logic        decrypt_q, decrypt_d;
`endif

  logic        first_beat;
  logic        final_beat;
  logic        in_xfer;
  logic        load;
  logic [1:0]  row_idx;
  col_t        asm_col;
  col_t        mixed_col;

  // Input side: row assembly and mode latching.
  always_comb begin
    first_beat = (byte_cnt_q == 2'd0);
    final_beat = (byte_cnt_q == LAST_BYTE_CNT);
    // Only the completing beat needs room in the output register.
    in_ready   = !final_beat || !out_valid_q || out_ready;
    in_xfer    = in_valid && in_ready;
    load       = in_xfer && final_beat;

    row_d      = row_q;
    byte_cnt_d = byte_cnt_q;
    bypass_d   = bypass_q;
`ifdef MIXCOL_INV_EN
    decrypt_d  = decrypt_q;
`endif
    row_idx    = '0;

    if (in_xfer) begin
      for (int k = 0; k < LANES; k++) begin
        row_idx        = byte_cnt_q + 2'(k);
        row_d[row_idx] = in_data[8*k +: 8];
      end
      byte_cnt_d = byte_cnt_q + LANE_STEP;
      if (first_beat) begin
        bypass_d = bypass;
`ifdef MIXCOL_INV_EN
        decrypt_d = decrypt;
`endif
      end
    end

    // The transform sees the column including the beat being accepted now,
    // and the mode that applies to it (fresh on a single-beat column).
    asm_col = {row_d[0], row_d[1], row_d[2], row_d[3]};
  end

  mix_column_comb u_mix (
    .col_in  (asm_col),
    .bypass  (bypass_d),
`ifdef MIXCOL_INV_EN
    .inv     (decrypt_d),
`endif
    .col_out (mixed_col)
  );

  // Output register: a load in the drain cycle overrides the drain.
  always_comb begin
    out_valid_d = out_valid_q;
    out_col_d   = out_col_q;
    out_last_d  = out_last_q;
    col_cnt_d   = col_cnt_q;

    if (load) begin
      out_valid_d = 1'b1;
      out_col_d   = mixed_col;
      out_last_d  = (col_cnt_q == LAST_COL);
      col_cnt_d   = (col_cnt_q == LAST_COL) ? 3'd0 : col_cnt_q + 3'd1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      byte_cnt_q  <= '0;
      col_cnt_q   <= '0;
      bypass_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_col_q   <= '0;
      out_last_q  <= 1'b0;
      for (int i = 0; i < 4; i++) row_q[i] <= '0;
`ifdef MIXCOL_INV_EN
      decrypt_q   <= 1'b0;
`endif
    end else begin
      byte_cnt_q  <= byte_cnt_d;
      col_cnt_q   <= col_cnt_d;
      bypass_q    <= bypass_d;
      out_valid_q <= out_valid_d;
      out_col_q   <= out_col_d;
      out_last_q  <= out_last_d;
      row_q       <= row_d;
`ifdef MIXCOL_INV_EN
      decrypt_q   <= decrypt_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_col   = out_col_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_mix_columns_stream.sv
// Bench for mix_columns_stream: one LANES=1 and one LANES=4 instance, both
// NB=4, sharing clock and reset. Expected columns come from known vectors or
// from a field-arithmetic reference model; a per-instance monitor checks
// every output transfer against an expected queue and checks that stalled
// outputs hold. Define MIXCOL_INV_EN to also cover the inverse transform.
module tb_mix_columns_stream;

  localparam int NB = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  logic        in_valid1, in_ready1, bypass1, decrypt1, out_valid1, out_ready1, out_last1;
  logic [7:0]  in_data1;
  logic [31:0] out_col1;
  logic        in_valid4, in_ready4, bypass4, decrypt4, out_valid4, out_ready4, out_last4;
  logic [31:0] in_data4;
  logic [31:0] out_col4;

  int errors = 0;
  int checks = 0;
  logic [32:0] exp1_q[$];
  logic [32:0] exp4_q[$];
  int col_idx1 = 0;
  int col_idx4 = 0;

  mix_columns_stream #(.LANES(1), .NB(NB)) dut1 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1), .bypass(bypass1),
`ifdef MIXCOL_INV_EN
    .decrypt(decrypt1),
`endif
    .out_valid(out_valid1), .out_ready(out_ready1), .out_col(out_col1), .out_last(out_last1)
  );

  mix_columns_stream #(.LANES(4), .NB(NB)) dut4 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .bypass(bypass4),
`ifdef MIXCOL_INV_EN
    .decrypt(decrypt4),
`endif
    .out_valid(out_valid4), .out_ready(out_ready4), .out_col(out_col4), .out_last(out_last4)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [8:0] x = {1'b0, a};
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x[7:0];
      x = {x[7:0], 1'b0};
      if (x[8]) x = x ^ 9'h11B;
    end
    return p;
  endfunction

  function automatic logic [31:0] ref_mix(input logic [31:0] col, input bit inv, input bit byp);
    logic [7:0] a[4];
    logic [7:0] c[4];
    logic [7:0] b[4];
    if (byp) return col;
    for (int r = 0; r < 4; r++) a[r] = col[31-8*r -: 8];
    if (inv) begin c[0] = 8'h0e; c[1] = 8'h0b; c[2] = 8'h0d; c[3] = 8'h09; end
    else     begin c[0] = 8'h02; c[1] = 8'h03; c[2] = 8'h01; c[3] = 8'h01; end
    for (int r = 0; r < 4; r++) begin
      b[r] = 8'h00;
      for (int j = 0; j < 4; j++) b[r] = b[r] ^ gmul(c[(j - r + 4) % 4], a[j]);
    end
    return {b[0], b[1], b[2], b[3]};
  endfunction

  // ---------------- output monitors ----------------
  logic [32:0] held1, held4;
  bit stalled1 = 0, stalled4 = 0;

  always @(negedge clock) begin
    if (reset) begin
      stalled1 = 0;
    end else begin
      if (stalled1) begin
        checks++;
        if (out_valid1 !== 1'b1 || {out_last1, out_col1} !== held1) begin
          errors++;
          $display("FAIL hold1: got valid=%b last=%b col=%h want valid=1 last=%b col=%h",
                   out_valid1, out_last1, out_col1, held1[32], held1[31:0]);
        end
      end
      if (out_valid1 === 1'b1 && out_ready1 === 1'b1) begin
        logic [32:0] e;
        checks++;
        if (exp1_q.size() == 0) begin
          errors++;
          $display("FAIL out1_unexpected: got last=%b col=%h want no transfer", out_last1, out_col1);
        end else begin
          e = exp1_q.pop_front();
          if ({out_last1, out_col1} !== e) begin
            errors++;
            $display("FAIL out1: got last=%b col=%h want last=%b col=%h",
                     out_last1, out_col1, e[32], e[31:0]);
          end
        end
      end
      stalled1 = (out_valid1 === 1'b1) && (out_ready1 === 1'b0);
      held1    = {out_last1, out_col1};
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      stalled4 = 0;
    end else begin
      if (stalled4) begin
        checks++;
        if (out_valid4 !== 1'b1 || {out_last4, out_col4} !== held4) begin
          errors++;
          $display("FAIL hold4: got valid=%b last=%b col=%h want valid=1 last=%b col=%h",
                   out_valid4, out_last4, out_col4, held4[32], held4[31:0]);
        end
      end
      if (out_valid4 === 1'b1 && out_ready4 === 1'b1) begin
        logic [32:0] e;
        checks++;
        if (exp4_q.size() == 0) begin
          errors++;
          $display("FAIL out4_unexpected: got last=%b col=%h want no transfer", out_last4, out_col4);
        end else begin
          e = exp4_q.pop_front();
          if ({out_last4, out_col4} !== e) begin
            errors++;
            $display("FAIL out4: got last=%b col=%h want last=%b col=%h",
                     out_last4, out_col4, e[32], e[31:0]);
          end
        end
      end
      stalled4 = (out_valid4 === 1'b1) && (out_ready4 === 1'b0);
      held4    = {out_last4, out_col4};
    end
  end

  // ---------------- drivers ----------------
  // Present one beat and return at posedge+1 after it has been accepted.
  task automatic drive1(input logic [7:0] d, input logic byp, input logic dec, input bit rnd_rdy);
    bit done = 0;
    int n = 0;
    in_valid1 = 1'b1; in_data1 = d; bypass1 = byp; decrypt1 = dec;
    while (!done) begin
      if (rnd_rdy) out_ready1 = 1'($urandom_range(0, 1));
      @(negedge clock);
      if (in_ready1 === 1'b1) done = 1;
      else if (n == 100) begin
        checks++; errors++;
        $display("FAIL in_ready1_timeout: got in_ready=0 for 100 cycles want 1");
        done = 1;
      end
      n++;
      @(posedge clock); #1;
    end
    in_valid1 = 1'b0;
  endtask

  task automatic drive4(input logic [31:0] d, input logic byp, input logic dec, input bit rnd_rdy);
    bit done = 0;
    int n = 0;
    in_valid4 = 1'b1; in_data4 = d; bypass4 = byp; decrypt4 = dec;
    while (!done) begin
      if (rnd_rdy) out_ready4 = 1'($urandom_range(0, 1));
      @(negedge clock);
      if (in_ready4 === 1'b1) done = 1;
      else if (n == 100) begin
        checks++; errors++;
        $display("FAIL in_ready4_timeout: got in_ready=0 for 100 cycles want 1");
        done = 1;
      end
      n++;
      @(posedge clock); #1;
    end
    in_valid4 = 1'b0;
  endtask

  // One column on the byte-wide instance; later beats carry inverted modes,
  // which must be ignored.
  task automatic send_col1(input logic [31:0] col, input logic byp, input logic dec,
                           input logic [31:0] exp_col, input bit rnd_rdy, input bit gaps);
    for (int r = 0; r < 4; r++) begin
      if (gaps && $urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) begin @(posedge clock); #1; end
      if (r == 3) begin
        exp1_q.push_back({(col_idx1 == NB - 1), exp_col});
        col_idx1 = (col_idx1 + 1) % NB;
      end
      drive1(col[31-8*r -: 8], (r == 0) ? byp : ~byp, (r == 0) ? dec : ~dec, rnd_rdy);
    end
  endtask

  task automatic send_col4(input logic [31:0] col, input logic byp, input logic dec,
                           input logic [31:0] exp_col, input bit rnd_rdy);
    exp4_q.push_back({(col_idx4 == NB - 1), exp_col});
    col_idx4 = (col_idx4 + 1) % NB;
    drive4({col[7:0], col[15:8], col[23:16], col[31:24]}, byp, dec, rnd_rdy);
  endtask

  task automatic drain1();
    int n = 0;
    out_ready1 = 1'b1;
    while (exp1_q.size() != 0 && n < 50) begin @(posedge clock); n++; end
    #1;
    checks++;
    if (exp1_q.size() != 0) begin
      errors++;
      $display("FAIL drain1: got %0d columns outstanding want 0", exp1_q.size());
      exp1_q.delete();
    end
  endtask

  task automatic drain4();
    int n = 0;
    out_ready4 = 1'b1;
    while (exp4_q.size() != 0 && n < 50) begin @(posedge clock); n++; end
    #1;
    checks++;
    if (exp4_q.size() != 0) begin
      errors++;
      $display("FAIL drain4: got %0d columns outstanding want 0", exp4_q.size());
      exp4_q.delete();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    in_valid1 = 0; in_data1 = '0; bypass1 = 0; decrypt1 = 0; out_ready1 = 1;
    in_valid4 = 0; in_data4 = '0; bypass4 = 0; decrypt4 = 0; out_ready4 = 1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({out_valid1, out_last1, in_ready1, out_col1} !== {3'b001, 32'h0}) begin
      errors++;
      $display("FAIL reset1: got valid=%b last=%b in_ready=%b col=%h want 0 0 1 00000000",
               out_valid1, out_last1, in_ready1, out_col1);
    end
    checks++;
    if ({out_valid4, out_last4, in_ready4, out_col4} !== {3'b001, 32'h0}) begin
      errors++;
      $display("FAIL reset4: got valid=%b last=%b in_ready=%b col=%h want 0 0 1 00000000",
               out_valid4, out_last4, in_ready4, out_col4);
    end
    reset = 1'b0;
    col_idx1 = 0; col_idx4 = 0;
    @(posedge clock); #1;
  endtask

  task automatic test_known_vectors();
    send_col1(32'hdb135345, 0, 0, 32'h8e4da1bc, 0, 0);
    checks++;
    if ({out_valid1, out_col1} !== {1'b1, 32'h8e4da1bc}) begin
      errors++;
      $display("FAIL latency1: got valid=%b col=%h one cycle after last byte want 1 8e4da1bc",
               out_valid1, out_col1);
    end
    send_col1(32'hf20a225c, 0, 0, 32'h9fdc589d, 0, 0);
    send_col1(32'hc6c6c6c6, 0, 0, 32'hc6c6c6c6, 0, 0);
    send_col1(32'hd4bf5d30, 0, 0, 32'h046681e5, 0, 0);
    drain1();
  endtask

  task automatic test_fips_lanes4();
    logic [31:0] in_c[4];
    logic [31:0] out_c[4];
    in_c[0] = 32'hd4bf5d30; out_c[0] = 32'h046681e5;
    in_c[1] = 32'he0b452ae; out_c[1] = 32'he0cb199a;
    in_c[2] = 32'hb84111f1; out_c[2] = 32'h48f8d37a;
    in_c[3] = 32'h1e2798e5; out_c[3] = 32'h2806264c;
    for (int blk = 0; blk < 2; blk++)
      for (int i = 0; i < 4; i++) send_col4(in_c[i], 0, 0, out_c[i], 0);
    drain4();
  endtask

  task automatic test_bypass();
    send_col1(32'h01020304, 1, 0, 32'h01020304, 0, 0);
    send_col1(32'h01020304, 0, 0, ref_mix(32'h01020304, 0, 0), 0, 0);
    send_col4(32'hd4bf5d30, 1, 0, 32'hd4bf5d30, 0);
    send_col4(32'hd4bf5d30, 0, 0, 32'h046681e5, 0);
    drain1();
    drain4();
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b;
    int start;
    a = $urandom; b = $urandom;
    out_ready1 = 1'b0;
    send_col1(a, 0, 0, ref_mix(a, 0, 0), 0, 0);
    for (int r = 0; r < 3; r++) begin
      checks++;
      if (in_ready1 !== 1'b1) begin
        errors++;
        $display("FAIL stall_nonfinal: got in_ready=%b on byte %0d want 1", in_ready1, r);
      end
      drive1(b[31-8*r -: 8], 0, 0, 0);
    end
    in_valid1 = 1'b1; in_data1 = b[7:0];
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      checks++;
      if (in_ready1 !== 1'b0) begin
        errors++;
        $display("FAIL stall_final: got in_ready=%b while output full want 0", in_ready1);
      end
      @(posedge clock); #1;
    end
    exp1_q.push_back({(col_idx1 == NB - 1), ref_mix(b, 0, 0)});
    col_idx1 = (col_idx1 + 1) % NB;
    out_ready1 = 1'b1;
    @(negedge clock);
    checks++;
    if (in_ready1 !== 1'b1) begin
      errors++;
      $display("FAIL drain_and_load: got in_ready=%b with out_ready=1 want 1", in_ready1);
    end
    @(posedge clock); #1;
    in_valid1 = 1'b0;
    drain1();
    // Full throughput: 8 columns of 4 bytes take exactly 32 cycles.
    start = cyc;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      send_col1(a, 0, 0, ref_mix(a, 0, 0), 0, 0);
    end
    checks++;
    if (cyc - start != 32) begin
      errors++;
      $display("FAIL back_to_back: got %0d cycles for 32 bytes want 32", cyc - start);
    end
    drain1();
  endtask

  task automatic test_reset_mid();
    logic [31:0] a;
    a = $urandom;
    out_ready1 = 1'b0;
    send_col1(a, 0, 0, ref_mix(a, 0, 0), 0, 0);
    drive1(8'h11, 0, 0, 0);
    drive1(8'h22, 0, 0, 0);
    checks++;
    if (out_valid1 !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_valid: got out_valid=%b want 1", out_valid1);
    end
    reset = 1'b1;
    @(posedge clock); #1;
    exp1_q.delete(); exp4_q.delete();
    col_idx1 = 0; col_idx4 = 0;
    checks++;
    if ({out_valid1, out_last1, in_ready1, out_col1} !== {3'b001, 32'h0}) begin
      errors++;
      $display("FAIL reset_mid: got valid=%b last=%b in_ready=%b col=%h want 0 0 1 00000000",
               out_valid1, out_last1, in_ready1, out_col1);
    end
    reset = 1'b0;
    out_ready1 = 1'b1;
    send_col1(32'hc6c6c6c6, 0, 0, 32'hc6c6c6c6, 0, 0);
    for (int i = 0; i < 3; i++) begin
      a = $urandom;
      send_col1(a, 0, 0, ref_mix(a, 0, 0), 0, 0);
    end
    drain1();
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic byp;
    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      byp = ($urandom_range(0, 7) == 0);
      send_col1(a, byp, 0, ref_mix(a, 0, byp), 1, 1);
    end
    drain1();
    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      byp = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin @(posedge clock); #1; end
      send_col4(a, byp, 0, ref_mix(a, 0, byp), 1);
    end
    drain4();
  endtask

`ifdef MIXCOL_INV_EN
  task automatic test_inverse();
    logic [31:0] a, f;
    send_col1(32'h8e4da1bc, 0, 1, 32'hdb135345, 0, 0);
    send_col1(32'h01020304, 1, 1, 32'h01020304, 0, 0);
    drain1();
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      f = ref_mix(a, 0, 0);
      send_col4(a, 0, 0, f, 1);
      send_col4(f, 0, 1, a, 1);
    end
    drain4();
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion within time limit want completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_known_vectors();
    test_fips_lanes4();
    test_bypass();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef MIXCOL_INV_EN
    test_inverse();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
